// File: rtl/proj_pkg.sv
// Shared constants and types for the minhash pipeline; this slice carries the
// base encodings and the one-hot fragment decoder sizing.
package proj_pkg;

    localparam int BASE_LEN              = 2;
    localparam int ONE_HOT_LEN           = 4;
    localparam int EXTENDER_OUT_PART_LEN = 8;
    localparam int FRAG_DEC_FRAG_LEN     = 64;
    localparam int FRAG_DEC_LEN_BITS     = 7;

    typedef enum logic [BASE_LEN-1:0] {
        BASE_A = 2'b00,
        BASE_C = 2'b01,
        BASE_G = 2'b10,
        BASE_T = 2'b11
    } base_e;

    typedef struct packed {
        logic  valid;
        logic  err;
        base_e code;
    } dec_base_t;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } frag_state_e;

    // valid=0 marks padding; any multi-hot pattern is still a base, decoded as A.
    function automatic dec_base_t onehot_to_base(input logic [ONE_HOT_LEN-1:0] onehot);
        dec_base_t r;
        r = '{valid: 1'b1, err: 1'b0, code: BASE_A};
        case (onehot)
            4'b0001: r.code = BASE_A;
            4'b0010: r.code = BASE_C;
            4'b0100: r.code = BASE_G;
            4'b1000: r.code = BASE_T;
            4'b0000: r.valid = 1'b0;
            default: r.err = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/proj_onehot_base_dec.sv
// Combinational decode of one one-hot base into its packed code plus
// padding/error qualifiers.
module proj_onehot_base_dec
    import proj_pkg::*;
(
    input  logic [ONE_HOT_LEN-1:0] onehot,
    output logic                   valid,
    output logic                   err,
    output logic [BASE_LEN-1:0]    code
);

    dec_base_t dec;

    always_comb begin
        dec   = onehot_to_base(onehot);
        valid = dec.valid;
        err   = dec.err;
        code  = dec.code;
    end

endmodule

// File: rtl/proj_frag_decoder.sv
// Reassembles one-hot fragment beats into packed fragments and presents them on
// a valid/ready output slot; a second fragment may wait in the accumulator.
module proj_frag_decoder
    import proj_pkg::*;
#(
    parameter int FRAG_PART = EXTENDER_OUT_PART_LEN,
    parameter int FRAG_LEN  = FRAG_DEC_FRAG_LEN,
    parameter int LEN_BITS  = FRAG_DEC_LEN_BITS
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [FRAG_PART*ONE_HOT_LEN-1:0] in_gfm,
    input  logic                            in_valid,
    input  logic                            in_last,
    output logic                            in_ready,
    output logic [FRAG_LEN*BASE_LEN-1:0]    out_frag,
    output logic [LEN_BITS-1:0]             out_len,
    output logic                            out_err,
    output logic                            out_ovf,
    output logic                            out_valid,
    input  logic                            out_ready
);

    logic [FRAG_PART-1:0]               dec_valid;
    logic [FRAG_PART-1:0]               dec_err;
    logic [FRAG_PART-1:0][BASE_LEN-1:0] dec_code;

    for (genvar g = 0; g < FRAG_PART; g++) begin : g_dec
        proj_onehot_base_dec u_dec (
            .onehot (in_gfm[g*ONE_HOT_LEN +: ONE_HOT_LEN]),
            .valid  (dec_valid[g]),
            .err    (dec_err[g]),
            .code   (dec_code[g])
        );
    end

    frag_state_e state, state_nxt;

    logic [FRAG_LEN*BASE_LEN-1:0] acc_frag;
    logic [LEN_BITS-1:0]          acc_cnt;
    logic                         acc_err, acc_ovf, acc_pad;

    // Accumulator contents after merging the current beat.
    logic [FRAG_LEN*BASE_LEN-1:0] m_frag;
    logic [LEN_BITS-1:0]          m_cnt;
    logic                         m_err, m_ovf, m_pad;

    logic accept, out_fire, slot_free;
    logic load_from_beat, load_from_acc, acc_update, acc_clear;

    // Once padding is seen, every later base up to in_last is ignored, so valid
    // bases always form a contiguous run starting at acc_cnt.
    always_comb begin
        int n;
        int pos;
        int total;
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        m_frag = acc_frag;
        m_err  = acc_err;
        m_ovf  = acc_ovf;
        m_pad  = acc_pad;
        n      = 0;
        pos    = 0;
        for (int k = 0; k < FRAG_PART; k++) begin
            if (!dec_valid[k]) begin
                m_pad = 1'b1;
            end else if (!m_pad) begin
                pos = int'(acc_cnt) + n;
                if (pos < FRAG_LEN) m_frag[pos*BASE_LEN +: BASE_LEN] = dec_code[k];
                else                m_ovf = 1'b1;
                m_err = m_err | dec_err[k];
                n     = n + 1;
            end
        end
        total = int'(acc_cnt) + n;
        m_cnt = (total > FRAG_LEN) ? LEN_BITS'(FRAG_LEN) : LEN_BITS'(total);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (rst) state <= ST_ACCUM;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_ACCUM: if (accept && in_last && !slot_free) state_nxt = ST_HOLD;
            ST_HOLD:  if (out_fire)                        state_nxt = ST_ACCUM;
            default:                                       state_nxt = ST_ACCUM;
        endcase
    end

    always_comb begin
        in_ready       = (state == ST_ACCUM);
        accept         = in_valid && in_ready;
        out_fire       = out_valid && out_ready;
        slot_free      = !out_valid || out_ready;
        load_from_beat = accept && in_last && slot_free;
        load_from_acc  = (state == ST_HOLD) && out_fire;
        acc_update     = accept && !load_from_beat;
        acc_clear      = load_from_beat || load_from_acc;
    end

    always_ff @(posedge clk) begin
        if (rst || acc_clear) begin
            acc_frag <= '0;
            acc_cnt  <= '0;
            acc_err  <= 1'b0;
            acc_ovf  <= 1'b0;
            acc_pad  <= 1'b0;
        end else if (acc_update) begin
            acc_frag <= m_frag;
            acc_cnt  <= m_cnt;
            acc_err  <= m_err;
            acc_ovf  <= m_ovf;
            acc_pad  <= m_pad;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_frag  <= '0;
            out_len   <= '0;
            out_err   <= 1'b0;
            out_ovf   <= 1'b0;
        end else if (load_from_beat) begin
            out_valid <= 1'b1;
            out_frag  <= m_frag;
            out_len   <= m_cnt;
            out_err   <= m_err;
            out_ovf   <= m_ovf;
        end else if (load_from_acc) begin
            out_valid <= 1'b1;
            out_frag  <= acc_frag;
            out_len   <= acc_cnt;
            out_err   <= acc_err;
            out_ovf   <= acc_ovf;
        end else if (out_fire) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_proj_frag_decoder.sv
// Directed bench for proj_frag_decoder: hand-computed fragments, error,
// padding, overflow, back-pressure and reset cases.
module tb_proj_frag_decoder;

    localparam logic [3:0] OH_A = 4'b0001;
    localparam logic [3:0] OH_C = 4'b0010;
    localparam logic [3:0] OH_G = 4'b0100;
    localparam logic [3:0] OH_T = 4'b1000;
    localparam logic [3:0] OH_0 = 4'b0000;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  in_gfm;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;
    logic [127:0] out_frag;
    logic [6:0]   out_len;
    logic         out_err;
    logic         out_ovf;
    logic         out_valid;
    logic         out_ready;

    int n_cmp = 0;
    int n_bad = 0;

    proj_frag_decoder dut (
        .clk       (clk),
        .rst       (rst),
        .in_gfm    (in_gfm),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_frag  (out_frag),
        .out_len   (out_len),
        .out_err   (out_err),
        .out_ovf   (out_ovf),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] beat8(input logic [3:0] b0, b1, b2, b3, b4, b5, b6, b7);
        return {b7, b6, b5, b4, b3, b2, b1, b0};
    endfunction

    // Present a beat, wait (bounded) for in_ready, let one edge accept it.
    task automatic send_beat(input logic [31:0] d, input logic last);
        int waited = 0;
        in_gfm   = d;
        in_last  = last;
        in_valid = 1'b1;
        while (!in_ready && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        check("send_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic [127:0] frag, input logic [6:0] len,
                             input logic err, input logic ovf);
        check({tag, ".valid"}, out_valid, 1);
        check({tag, ".frag"},  out_frag,  frag);
        check({tag, ".len"},   out_len,   len);
        check({tag, ".err"},   out_err,   err);
        check({tag, ".ovf"},   out_ovf,   ovf);
    endtask

    logic [31:0]  b_t1, b_t2, b_t3, b_err, b_allt, b_zero;
    logic [127:0] f_t1, f_3beat, f_err, f_ovf, f_allt;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        b_t1   = beat8(OH_C, OH_A, OH_G, OH_T, OH_A, OH_A, OH_C, OH_G);
        b_t2   = beat8(OH_T, OH_G, OH_C, OH_A, OH_T, OH_G, OH_C, OH_A);
        b_t3   = beat8(OH_T, OH_T, OH_T, OH_T, OH_0, OH_0, OH_0, OH_0);
        b_err  = beat8(OH_C, OH_A, 4'b0110, OH_T, OH_A, OH_A, OH_C, OH_G);
        b_allt = {8{OH_T}};
        b_zero = '0;
        f_t1    = {112'b0, 16'b10_01_00_00_11_10_00_01};
        f_3beat = {88'b0, 8'hFF, 16'b00_01_10_11_00_01_10_11, 16'b10_01_00_00_11_10_00_01};
        f_err   = {112'b0, 16'b10_01_00_00_11_00_00_01};
        f_ovf   = 128'hFFFF_AAAA_5555_0000_FFFF_AAAA_5555_0000;
        f_allt  = {112'b0, 16'hFFFF};

        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_gfm = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.valid", out_valid, 0);
        check("rst.frag",  out_frag,  0);
        check("rst.len",   out_len,   0);
        check("rst.err",   out_err,   0);
        check("rst.ovf",   out_ovf,   0);
        check("rst.ready", in_ready,  1);
        rst = 1'b0;
        out_ready = 1'b1;

        // Single-beat fragment.
        send_beat(b_t1, 1'b1);
        check_out("single", f_t1, 7'd8, 1'b0, 1'b0);

        // Three beats, padding in the last.
        send_beat(b_t1, 1'b0);
        send_beat(b_t2, 1'b0);
        send_beat(b_t3, 1'b1);
        check_out("pad3", f_3beat, 7'd20, 1'b0, 1'b0);

        // All-padding fragment.
        send_beat(b_zero, 1'b1);
        check_out("empty", '0, 7'd0, 1'b0, 1'b0);

        // Multi-hot base, then a clean fragment.
        send_beat(b_err, 1'b1);
        check_out("err", f_err, 7'd8, 1'b1, 1'b0);
        send_beat(b_t1, 1'b1);
        check_out("clean", f_t1, 7'd8, 1'b0, 1'b0);

        // Nine full beats: beat j carries base code j%4 throughout.
        for (int j = 0; j < 9; j++) begin
            logic [3:0] oh;
            oh = 4'b0001 << (j % 4);
            send_beat({8{oh}}, j == 8);
        end
        check_out("ovf", f_ovf, 7'd64, 1'b0, 1'b1);
        @(posedge clk); #1;
        check("ovf.drain", out_valid, 0);

        // Back-pressure: first fragment held, second waits in HOLD.
        out_ready = 1'b0;
        send_beat(b_t1, 1'b1);
        check_out("bp.first", f_t1, 7'd8, 1'b0, 1'b0);
        send_beat(b_allt, 1'b1);
        check("bp.hold_ready", in_ready, 0);
        check("bp.hold_frag",  out_frag, f_t1);
        repeat (2) @(posedge clk);
        #1;
        check_out("bp.stable", f_t1, 7'd8, 1'b0, 1'b0);
        check("bp.still_hold", in_ready, 0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check_out("bp.second", f_allt, 7'd8, 1'b0, 1'b0);
        check("bp.ready_back", in_ready, 1);
        @(posedge clk); #1;
        check("bp.drained", out_valid, 0);

        // Reset during a partial fragment.
        send_beat(b_allt, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rstp.valid", out_valid, 0);
        check("rstp.ready", in_ready,  1);
        send_beat(b_t1, 1'b1);
        check_out("rstp.after", f_t1, 7'd8, 1'b0, 1'b0);
        @(posedge clk); #1;

        // Reset during HOLD.
        out_ready = 1'b0;
        send_beat(b_allt, 1'b1);
        send_beat(b_err, 1'b1);
        check("rsth.hold", in_ready, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rsth.valid", out_valid, 0);
        check("rsth.ready", in_ready,  1);
        out_ready = 1'b1;
        send_beat(b_t1, 1'b1);
        check_out("rsth.after", f_t1, 7'd8, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("rsth.drained", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/proj_frag_decoder.md
Name: proj_frag_decoder

Overview:
- Consumer at the output end of the minhash pipeline.
- Accepts the one-hot-encoded fragment stream produced by the extender, FRAG_PART bases per beat.
- Decodes each one-hot base back to the packed BASE_LEN code and reassembles whole fragments of up to FRAG_LEN bases.
- Presents each fragment on a valid/ready output with length and error flags, so fragments can be written back or compared against the input reads.

Parameters:
BASE_LEN, 2, bits per packed base (A=00, C=01, G=10, T=11)
ONE_HOT_LEN, 4, bits per one-hot base (A=0001, C=0010, G=0100, T=1000)
FRAG_PART, 8, bases per input beat
FRAG_LEN, 64, maximum bases per fragment (multiple of FRAG_PART)
LEN_BITS, 7, width of base counter/out_len; must satisfy 2^LEN_BITS > FRAG_LEN

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
in_gfm  in  FRAG_PART*ONE_HOT_LEN  one-hot beat; base k at bits [4k+3:4k], base 0 first
in_valid  in  1  beat valid
in_last  in  1  final beat of current fragment
in_ready  out  1  decoder accepts beat this cycle
out_frag  out  FRAG_LEN*BASE_LEN  packed fragment; base i at bits [2i+1:2i]; unused bases zero
out_len  out  LEN_BITS  number of valid bases in out_frag
out_err  out  1  fragment contained a multi-hot base
out_ovf  out  1  fragment exceeded FRAG_LEN bases; excess dropped
out_valid  out  1  output fragment valid
out_ready  in  1  downstream accepts fragment

Behaviour:
- Reset (rst=1 at a clk edge):
  - out_valid=0, out_frag=0, out_len=0, out_err=0, out_ovf=0, in_ready=1.
  - Accumulator cleared; state=ACCUM.
  - Reset mid-fragment discards all partial and held data.
- Accept: a beat is accepted when in_valid && in_ready. Output handshake completes when out_valid && out_ready.
- Per-base decode:
  - 0001/0010/0100/1000 -> 00/01/10/11.
  - 0000 -> padding. That base and every later base of the fragment is ignored until in_last, including bases in later beats.
  - Any other pattern -> decoded as 00, counted as a valid base, sets the sticky err for the fragment.
- Placement: valid bases are written at positions cnt..cnt+n-1, and cnt advances by n.
  - Positions >= FRAG_LEN are dropped, cnt saturates at FRAG_LEN, and the sticky ovf is set.
- Two registers:
  - Accumulator: frag, cnt, err, ovf, pad_seen.
  - Output slot: drives out_*.
- FSM:
  - ACCUM: in_ready=1. When a beat with in_last is accepted, the completed fragment (including that beat's bases) goes to the output slot if the slot is empty or handshakes this same cycle. The accumulator then clears and the state stays ACCUM. Otherwise the fragment stays in the accumulator and the state becomes HOLD.
  - HOLD: in_ready=0. On an output handshake, the accumulator transfers to the output slot on the same edge, the accumulator clears, and the state returns to ACCUM.
- Latency: in_last accepted at edge N -> out_valid=1 after edge N (visible cycle N+1). Sustained throughput is 1 beat/cycle while out_ready=1.
- Output stability: out_* hold unchanged while out_valid && !out_ready. out_valid drops after a handshake unless a new fragment is loaded on the same edge.
- Empty fragment: in_last with all-padding content is emitted with out_len=0 and out_frag=0.
- in_valid=0 beats leave all state untouched. in_last is ignored unless the beat is accepted.

Decomposition:
- Add to proj_pkg:
  - ONE_HOT_LEN and EXTENDER_OUT_PART_LEN (reuse the existing ones).
  - A base_e enum for A/C/G/T codes.
  - A function onehot_to_base returning {valid, err, code}.
  - FRAG_DEC_LEN_BITS.
- One sub-module, proj_onehot_base_dec: combinational decode of a single base, instantiated FRAG_PART times.
- The FSM and packing logic stay in proj_frag_decoder.

Test Plan:
- Single beat C,A,G,T,A,A,C,G (one-hot), in_last=1, out_ready=1 -> cycle N+1: out_valid=1, out_len=8, out_frag[15:0]=16'b10_01_00_00_11_10_00_01, err=0, ovf=0.
- Three beats where the third has bases 0-3=T and bases 4-7=0000, in_last on the third -> out_len=20, bases 16-19=11, bits 40 and up zero; also send an all-0000 single beat with in_last -> out_len=0.
- Beat with base 2=0110 -> out_err=1, base 2 decoded 00, out_len=8; next fragment clean -> out_err=0 (sticky only per fragment).
- Nine full beats (72 bases) -> out_len=64, out_ovf=1, bases 0-63 from the first eight beats.
- out_ready=0, send two complete one-beat fragments -> first held stable in output slot, second accepted, FSM enters HOLD with in_ready=0. Raise out_ready -> first handshakes, second appears next cycle, in_ready=1. No data lost or duplicated.
- Assert rst for one cycle during a partial fragment and during HOLD -> out_valid=0 and in_ready=1 next cycle; the following fragment decodes correctly from position 0.
